// File: rtl/tnn_pkg.sv
// Shared TNN types: spike-time encoding and the input-encoder state set.
// The same spike_time_t is reused by the neuron and STDP stages.
package tnn_pkg;

  localparam int SPIKE_TIME_W = 3;

  typedef logic [SPIKE_TIME_W-1:0] spike_time_t;

  // All-ones time means "this input does not fire in this gamma cycle".
  localparam spike_time_t NO_SPIKE = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    REST = 2'd2
  } enc_state_t;

endpackage

// File: rtl/spike_encoder_gamma_counter.sv
// Gamma-cycle sequencer: IDLE -> RUN (window slots 0..2^TIME_W-2) -> REST -> IDLE.
// Exposes next state/slot so the parent can register spikes aligned with the slot they belong to.
module gamma_counter
  import tnn_pkg::*;
#(
  parameter int TIME_W      = SPIKE_TIME_W,
  parameter int REST_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output enc_state_t        state_o,
  output enc_state_t        state_d_o,
  output logic [TIME_W-1:0] t_d_o,
  output logic              in_ready_o,
  output logic              gamma_start_o,
  output logic              gamma_done_o
);

  localparam int                REST_W = $clog2(REST_CYCLES + 1);
  localparam logic [TIME_W-1:0] T_LAST = TIME_W'((1 << TIME_W) - 2);
  localparam logic [REST_W-1:0] R_LAST = REST_W'(REST_CYCLES - 1);

  enc_state_t        state_q, state_d;
  logic [TIME_W-1:0] t_q, t_d;
  logic [REST_W-1:0] rest_q, rest_d;
  logic              in_ready_q, in_ready_d;
  logic              gamma_start_q, gamma_start_d;
  logic              gamma_done_q, gamma_done_d;

  always_comb begin
    state_d       = state_q;
    t_d           = t_q;
    rest_d        = rest_q;
    gamma_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d       = RUN;
          t_d           = '0;
          gamma_start_d = 1'b1;
        end
      end
      RUN: begin
        // The slot counter stops at T_LAST, so it never reaches the NO_SPIKE code.
        if (t_q == T_LAST) begin
          state_d = REST;
          rest_d  = '0;
        end else begin
          t_d = t_q + TIME_W'(1);
        end
      end
      REST: begin
        if (rest_q == R_LAST) begin
          state_d = IDLE;
        end else begin
          rest_d = rest_q + REST_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    gamma_done_d = (state_d == REST) && (rest_d == R_LAST);
    in_ready_d   = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      t_q           <= '0;
      rest_q        <= '0;
      in_ready_q    <= 1'b1;
      gamma_start_q <= 1'b0;
      gamma_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      t_q           <= t_d;
      rest_q        <= rest_d;
      in_ready_q    <= in_ready_d;
      gamma_start_q <= gamma_start_d;
      gamma_done_q  <= gamma_done_d;
    end
  end

  assign state_o       = state_q;
  assign state_d_o     = state_d;
  assign t_d_o         = t_d;
  assign in_ready_o    = in_ready_q;
  assign gamma_start_o = gamma_start_q;
  assign gamma_done_o  = gamma_done_q;

endmodule

// File: rtl/spike_encoder.sv
// Race-logic input encoder: latches one spike-time vector per gamma cycle and replays it as
// active-low one-cycle pulses. Handshake: a vector transfers on a rising edge where in_valid & in_ready.
module spike_encoder
  import tnn_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int TIME_W      = SPIKE_TIME_W,
  parameter int REST_CYCLES = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_INPUTS*TIME_W-1:0] in_times,
  output logic [NUM_INPUTS-1:0]        should_spike_out_l,
  output logic                         gamma_start,
  output logic                         gamma_done
);

  localparam logic [TIME_W-1:0] NO_SPIKE_T = '1;

  enc_state_t                   state, state_d;
  logic [TIME_W-1:0]            t_d;
  logic                         accept;
  logic                         run_next;
  logic [NUM_INPUTS*TIME_W-1:0] times_q, times_d;
  logic [NUM_INPUTS-1:0]        spikes_q, spikes_d;

  gamma_counter #(
    .TIME_W      (TIME_W),
    .REST_CYCLES (REST_CYCLES)
  ) u_gamma_counter (
    .clk_i         (clock),
    .rst_i         (reset),
    .in_valid_i    (in_valid),
    .state_o       (state),
    .state_d_o     (state_d),
    .t_d_o         (t_d),
    .in_ready_o    (in_ready),
    .gamma_start_o (gamma_start),
    .gamma_done_o  (gamma_done)
  );

  assign accept   = in_valid && (state == IDLE);
  assign times_d  = accept ? in_times : times_q;
  assign run_next = (state_d == RUN);

  // Compare against next-cycle slot so the registered pulse lands exactly in slot t.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cmp
    logic [TIME_W-1:0] time_i;
    assign time_i      = times_d[i*TIME_W +: TIME_W];
    assign spikes_d[i] = !(run_next && (time_i == t_d) && (time_i != NO_SPIKE_T));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      times_q  <= '0;
      spikes_q <= '1;
    end else begin
      times_q  <= times_d;
      spikes_q <= spikes_d;
    end
  end

  assign should_spike_out_l = spikes_q;

endmodule
